sim_test_monitor: RTL and testbench

Parametrised, multi-channel successor to the single-instance testbench pass/fail watcher. It observes NUM_CH sets of testreg outputs (progress, fail, pass) from one or more rcn_testregs instances. It reports progress events, detects a pass, a fail, a global clock timeout and a progress stall, and gives a single registered verdict after a drain delay. Simulation top levels instantiate it; the top level calls $finish when finish_req is seen.

---
 rtl/sim_test_pkg.sv | 33 +++
 rtl/sim_test_chan.sv | 59 +++++
 rtl/sim_test_monitor.sv | 199 +++++++++++++++++++
 tb/tb_sim_test_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_test_pkg.sv
// Shared encodings and helpers for the multi-channel simulation pass/fail monitor.
package sim_test_pkg;

  typedef enum logic [2:0] {
    VERDICT_RUN     = 3'd0,
    VERDICT_PASS    = 3'd1,
    VERDICT_FAIL    = 3'd2,
    VERDICT_TIMEOUT = 3'd3,
    VERDICT_STALL   = 3'd4
  } verdict_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Masks are padded to 16 bits so a channel index is always 4 bits wide.
  function automatic logic [3:0] lowest_set(input logic [15:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = i[3:0];
    end
    return idx;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sim_test_chan.sv
// One monitored testreg channel: progress shadow with change detect, sticky pass
// capture and a registered copy of the fail word.
module sim_test_chan (
  input  logic        sim_clk,
  input  logic        sim_rst,
  input  logic        load_i,
  input  logic        track_i,
  input  logic        pass_en_i,
  input  logic [31:0] progress_i,
  input  logic [31:0] fail_i,
  input  logic [31:0] pass_i,
  output logic        changed_o,
  output logic        pass_seen_o,
  output logic        fail_o,
  output logic [31:0] fail_word_o,
  output logic [31:0] pass_word_o
);
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] fail_q;
  logic [31:0] pass_word_q, pass_word_d;
  logic        pass_seen_q, pass_seen_d;

  assign changed_o   = track_i && (progress_i != shadow_q);
  assign pass_seen_o = pass_seen_q;
  assign fail_o      = (fail_q != 32'd0);
  assign fail_word_o = fail_q;
  assign pass_word_o = pass_word_q;

  always_comb begin
    shadow_d    = shadow_q;
    pass_word_d = pass_word_q;
    pass_seen_d = pass_seen_q;
    if (load_i || changed_o) shadow_d = progress_i;
    else                     shadow_d = shadow_q;
    // The pass flag is sticky; the word kept is the last nonzero pass value.
    if (pass_en_i && (pass_i != 32'd0)) begin
      pass_seen_d = 1'b1;
      pass_word_d = pass_i;
    end else begin
      pass_seen_d = pass_seen_q;
      pass_word_d = pass_word_q;
    end
  end

  always_ff @(posedge sim_clk or posedge sim_rst) begin
    if (sim_rst) begin
      shadow_q    <= 32'd0;
      fail_q      <= 32'd0;
      pass_word_q <= 32'd0;
      pass_seen_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      fail_q      <= fail_i;
      pass_word_q <= pass_word_d;
      pass_seen_q <= pass_seen_d;
    end
  end

endmodule

// File: rtl/sim_test_monitor.sv
// Multi-channel testreg watcher: progress events, prioritised pass/fail/timeout/stall
// verdict, drain delay and a one-shot finish request.
module sim_test_monitor
  import sim_test_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned PASS_MODE    = 1,
  parameter int unsigned MAX_CLOCKS   = 100000,
  parameter int unsigned STALL_LIMIT  = 20000,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                  sim_clk,
  input  logic                  sim_rst,
  input  logic [32*NUM_CH-1:0]  progress_in,
  input  logic [32*NUM_CH-1:0]  fail_in,
  input  logic [32*NUM_CH-1:0]  pass_in,
  output logic                  progress_evt,
  output logic [3:0]            progress_ch,
  output logic [31:0]           progress_val,
  output logic [2:0]            verdict,
  output logic [3:0]            verdict_ch,
  output logic [31:0]           verdict_val,
  output logic [31:0]           cycle_count,
  output logic                  done,
  output logic                  finish_req
);
  localparam logic [31:0] MAX_M1     = 32'(MAX_CLOCKS) - 32'd1;
  localparam logic [31:0] STALL_M1   = 32'(STALL_LIMIT) - 32'd1;
  localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYCLES);

  state_e      state_q, state_d;
  verdict_e    verdict_q, verdict_d;
  logic [3:0]  vch_q, vch_d, pch_q, pch_d;
  logic [31:0] vval_q, vval_d, pval_q, pval_d;
  logic [31:0] cycle_q, cycle_d, stall_q, stall_d;
  logic [7:0]  drain_q, drain_d;
  logic        evt_q, evt_d, done_q, done_d, fin_q, fin_d;

  logic        load_s, track_s, pass_en_s;
  logic [15:0] changed_s, pass_seen_s, pass_fill_s, fail_s;
  logic [31:0] prog_s [16];
  logic [31:0] fail_word_s [16];
  logic [31:0] pass_word_s [16];

  assign load_s    = (state_q == ST_INIT);
  assign track_s   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign pass_en_s = (state_q == ST_RUN);

  // Unused channel slots read as idle; their pass fill bit is 1 so the all-pass AND ignores them.
  for (genvar g = 0; g < 16; g++) begin : g_ch
    if (g < NUM_CH) begin : g_used
      assign prog_s[g]      = progress_in[32*g +: 32];
      assign pass_fill_s[g] = pass_seen_s[g];
      sim_test_chan u_chan (
        .sim_clk     (sim_clk),
        .sim_rst     (sim_rst),
        .load_i      (load_s),
        .track_i     (track_s),
        .pass_en_i   (pass_en_s),
        .progress_i  (progress_in[32*g +: 32]),
        .fail_i      (fail_in[32*g +: 32]),
        .pass_i      (pass_in[32*g +: 32]),
        .changed_o   (changed_s[g]),
        .pass_seen_o (pass_seen_s[g]),
        .fail_o      (fail_s[g]),
        .fail_word_o (fail_word_s[g]),
        .pass_word_o (pass_word_s[g])
      );
    end else begin : g_unused
      assign prog_s[g]      = 32'd0;
      assign changed_s[g]   = 1'b0;
      assign pass_seen_s[g] = 1'b0;
      assign pass_fill_s[g] = 1'b1;
      assign fail_s[g]      = 1'b0;
      assign fail_word_s[g] = 32'd0;
      assign pass_word_s[g] = 32'd0;
    end
  end

  logic        any_change_s, pass_hit_s, timeout_hit_s, stall_hit_s;
  logic [3:0]  chg_idx_s, fail_idx_s, pass_idx_s;
  logic [31:0] cycle_inc_s;

  assign any_change_s  = |changed_s;
  assign chg_idx_s     = lowest_set(changed_s);
  assign fail_idx_s    = lowest_set(fail_s);
  assign pass_idx_s    = lowest_set(pass_seen_s);
  assign pass_hit_s    = (PASS_MODE == 32'd0) ? (|pass_seen_s) : (&pass_fill_s);
  assign cycle_inc_s   = sat_inc32(cycle_q);
  assign timeout_hit_s = (MAX_CLOCKS != 32'd0) && (cycle_q == MAX_M1);
  assign stall_hit_s   = (STALL_LIMIT != 32'd0) && (stall_q == STALL_M1) && !any_change_s;

  // Next-state, counters, verdict latch and progress event generation.
  always_comb begin
    state_d   = state_q;
    verdict_d = verdict_q;
    vch_d     = vch_q;
    vval_d    = vval_q;
    cycle_d   = cycle_q;
    stall_d   = stall_q;
    drain_d   = drain_q;
    pch_d     = pch_q;
    pval_d    = pval_q;
    evt_d     = 1'b0;
    done_d    = done_q;
    fin_d     = 1'b0;
    if (any_change_s) begin
      evt_d  = 1'b1;
      pch_d  = chg_idx_s;
      pval_d = prog_s[chg_idx_s];
    end else begin
      evt_d = 1'b0;
    end
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        cycle_d = cycle_inc_s;
        stall_d = any_change_s ? 32'd0 : sat_inc32(stall_q);
        drain_d = 8'd0;
        if (fail_s != 16'd0) begin
          verdict_d = VERDICT_FAIL;
          vch_d     = fail_idx_s;
          vval_d    = fail_word_s[fail_idx_s];
          state_d   = ST_DRAIN;
        end else if (pass_hit_s) begin
          verdict_d = VERDICT_PASS;
          vch_d     = pass_idx_s;
          vval_d    = pass_word_s[pass_idx_s];
          state_d   = ST_DRAIN;
        end else if (timeout_hit_s) begin
          verdict_d = VERDICT_TIMEOUT;
          vch_d     = 4'd0;
          vval_d    = cycle_inc_s;
          state_d   = ST_DRAIN;
        end else if (stall_hit_s) begin
          verdict_d = VERDICT_STALL;
          vch_d     = 4'd0;
          vval_d    = cycle_inc_s;
          state_d   = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          fin_d   = 1'b1;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_INIT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sim_clk or posedge sim_rst) begin
    if (sim_rst) begin
      state_q   <= ST_INIT;
      verdict_q <= VERDICT_RUN;
      vch_q     <= 4'd0;
      vval_q    <= 32'd0;
      cycle_q   <= 32'd0;
      stall_q   <= 32'd0;
      drain_q   <= 8'd0;
      pch_q     <= 4'd0;
      pval_q    <= 32'd0;
      evt_q     <= 1'b0;
      done_q    <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      verdict_q <= verdict_d;
      vch_q     <= vch_d;
      vval_q    <= vval_d;
      cycle_q   <= cycle_d;
      stall_q   <= stall_d;
      drain_q   <= drain_d;
      pch_q     <= pch_d;
      pval_q    <= pval_d;
      evt_q     <= evt_d;
      done_q    <= done_d;
      fin_q     <= fin_d;
    end
  end

  assign progress_evt = evt_q;
  assign progress_ch  = pch_q;
  assign progress_val = pval_q;
  assign verdict      = verdict_q;
  assign verdict_ch   = vch_q;
  assign verdict_val  = vval_q;
  assign cycle_count  = cycle_q;
  assign done         = done_q;
  assign finish_req   = fin_q;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Scoreboard bench: three monitor instances (pass-all, timeout, stall/pass-any), directed stimulus.
module tb_sim_test_monitor;

  typedef struct packed {
    logic [1:0]  inst;
    logic [1:0]  kind;
    logic [2:0]  code;
    logic [3:0]  ch;
    logic [31:0] val;
    logic [31:0] aux;
  } rec_t;

  logic        clk;
  logic        rst_i   [3];
  logic [63:0] prog_i  [3];
  logic [63:0] fail_i  [3];
  logic [63:0] pass_i  [3];
  logic        evt_o   [3];
  logic [3:0]  pch_o   [3];
  logic [31:0] pval_o  [3];
  logic [2:0]  verd_o  [3];
  logic [3:0]  vch_o   [3];
  logic [31:0] vval_o  [3];
  logic [31:0] ccnt_o  [3];
  logic        done_o  [3];
  logic        fin_o   [3];

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sim_test_monitor #(.NUM_CH(2), .PASS_MODE(1), .MAX_CLOCKS(0), .STALL_LIMIT(0), .DRAIN_CYCLES(2)) u_a (
    .sim_clk(clk), .sim_rst(rst_i[0]), .progress_in(prog_i[0]), .fail_in(fail_i[0]), .pass_in(pass_i[0]),
    .progress_evt(evt_o[0]), .progress_ch(pch_o[0]), .progress_val(pval_o[0]), .verdict(verd_o[0]),
    .verdict_ch(vch_o[0]), .verdict_val(vval_o[0]), .cycle_count(ccnt_o[0]), .done(done_o[0]), .finish_req(fin_o[0]));

  sim_test_monitor #(.NUM_CH(2), .PASS_MODE(1), .MAX_CLOCKS(50), .STALL_LIMIT(0), .DRAIN_CYCLES(2)) u_b (
    .sim_clk(clk), .sim_rst(rst_i[1]), .progress_in(prog_i[1]), .fail_in(fail_i[1]), .pass_in(pass_i[1]),
    .progress_evt(evt_o[1]), .progress_ch(pch_o[1]), .progress_val(pval_o[1]), .verdict(verd_o[1]),
    .verdict_ch(vch_o[1]), .verdict_val(vval_o[1]), .cycle_count(ccnt_o[1]), .done(done_o[1]), .finish_req(fin_o[1]));

  sim_test_monitor #(.NUM_CH(2), .PASS_MODE(0), .MAX_CLOCKS(0), .STALL_LIMIT(10), .DRAIN_CYCLES(2)) u_c (
    .sim_clk(clk), .sim_rst(rst_i[2]), .progress_in(prog_i[2]), .fail_in(fail_i[2]), .pass_in(pass_i[2]),
    .progress_evt(evt_o[2]), .progress_ch(pch_o[2]), .progress_val(pval_o[2]), .verdict(verd_o[2]),
    .verdict_ch(vch_o[2]), .verdict_val(vval_o[2]), .cycle_count(ccnt_o[2]), .done(done_o[2]), .finish_req(fin_o[2]));

  function automatic rec_t mk(input int inst, input int kind, input logic [2:0] code,
                              input logic [3:0] ch, input logic [31:0] val, input logic [31:0] aux);
    rec_t r;
    r.inst = 2'(inst);
    r.kind = 2'(kind);
    r.code = code;
    r.ch   = ch;
    r.val  = val;
    r.aux  = aux;
    return r;
  endfunction

  function automatic string kname(input logic [1:0] k);
    return (k == 2'd0) ? "progress_evt" : (k == 2'd1) ? "verdict" : "finish";
  endfunction

  task automatic push(input int inst, input int kind, input logic [2:0] code,
                      input logic [3:0] ch, input logic [31:0] val, input logic [31:0] aux);
    exp_q.push_back(mk(inst, kind, code, ch, val, aux));
  endtask

  task automatic got(input rec_t r);
    rec_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s inst=%0d: got code=%0d ch=%0d val=%h aux=%0d, required none",
               kname(r.kind), r.inst, r.code, r.ch, r.val, r.aux);
    end else begin
      e = exp_q.pop_front();
      if (e !== r) begin
        n_bad++;
        $display("FAIL %s inst=%0d: got kind=%0d code=%0d ch=%0d val=%h aux=%0d, required inst=%0d kind=%0d code=%0d ch=%0d val=%h aux=%0d",
                 kname(e.kind), r.inst, r.kind, r.code, r.ch, r.val, r.aux,
                 e.inst, e.kind, e.code, e.ch, e.val, e.aux);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: turns DUT output activity into records and checks them against the scoreboard.
  initial begin
    logic [2:0] prev_v [3];
    int         since_v [3];
    for (int k = 0; k < 3; k++) begin
      prev_v[k]  = 3'd0;
      since_v[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (evt_o[k]) got(mk(k, 0, 3'd0, pch_o[k], pval_o[k], 32'd0));
        if (verd_o[k] != 3'd0 && prev_v[k] == 3'd0) begin
          got(mk(k, 1, verd_o[k], vch_o[k], vval_o[k], ccnt_o[k]));
          since_v[k] = 0;
        end else begin
          since_v[k]++;
        end
        if (fin_o[k]) got(mk(k, 2, verd_o[k], vch_o[k], vval_o[k], 32'(since_v[k])));
        prev_v[k] = verd_o[k];
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_i[k]  = 1'b1;
      prog_i[k] = 64'd0;
      fail_i[k] = 64'd0;
      pass_i[k] = 64'd0;
    end
    tick(2);
    chk("rst_evt",     {31'd0, evt_o[0]},  32'd0);
    chk("rst_verdict", {29'd0, verd_o[0]}, 32'd0);
    chk("rst_vval",    vval_o[0],          32'd0);
    chk("rst_cycles",  ccnt_o[0],          32'd0);
    chk("rst_done",    {31'd0, done_o[0]}, 32'd0);
    chk("rst_finish",  {31'd0, fin_o[0]},  32'd0);

    // Progress on ch1, pass on ch1 alone (no verdict), then ch0 completes the all-pass set.
    rst_i[0] = 1'b0;
    tick(3);
    prog_i[0][63:32] = 32'h5;
    push(0, 0, 3'd0, 4'd1, 32'h5, 32'd0);
    tick(2);
    pass_i[0][63:32] = 32'h1;
    tick(3);
    push(0, 1, 3'd1, 4'd0, 32'h1, 32'd9);
    push(0, 2, 3'd1, 4'd0, 32'h1, 32'd3);
    pass_i[0][31:0] = 32'h1;
    tick(8);
    chk("t1_done_level", {31'd0, done_o[0]}, 32'd1);
    chk("t1_finish_low", {31'd0, fin_o[0]},  32'd0);
    chk("t1_cycle_hold", ccnt_o[0],          32'd9);

    // Fail and pass in the same cycle: fail wins.
    rst_i[0]  = 1'b1;
    prog_i[0] = 64'd0;
    pass_i[0] = 64'd0;
    tick(1);
    rst_i[0] = 1'b0;
    tick(3);
    fail_i[0][63:32] = 32'hDEAD;
    pass_i[0][31:0]  = 32'h1;
    push(0, 1, 3'd2, 4'd1, 32'hDEAD, 32'd4);
    push(0, 2, 3'd2, 4'd1, 32'hDEAD, 32'd3);
    tick(8);
    chk("t2_verdict", {29'd0, verd_o[0]}, 32'd2);

    // Reset during DRAIN, then no spurious event with nonzero progress.
    rst_i[0]  = 1'b1;
    fail_i[0] = 64'd0;
    pass_i[0] = 64'd0;
    prog_i[0] = {32'h88, 32'h77};
    tick(1);
    rst_i[0] = 1'b0;
    tick(2);
    fail_i[0][31:0] = 32'h1;
    push(0, 1, 3'd2, 4'd0, 32'h1, 32'd3);
    tick(3);
    rst_i[0] = 1'b1;
    #1;
    chk("t5_verdict", {29'd0, verd_o[0]}, 32'd0);
    chk("t5_vch",     {28'd0, vch_o[0]},  32'd0);
    chk("t5_vval",    vval_o[0],          32'd0);
    chk("t5_cycles",  ccnt_o[0],          32'd0);
    chk("t5_done",    {31'd0, done_o[0]}, 32'd0);
    chk("t5_pval",    pval_o[0],          32'd0);
    fail_i[0] = 64'd0;
    tick(1);
    rst_i[0] = 1'b0;
    tick(6);
    chk("t5_run_cycles",  ccnt_o[0],          32'd5);
    chk("t5_run_verdict", {29'd0, verd_o[0]}, 32'd0);
    rst_i[0] = 1'b1;

    // Timeout on the 50th RUN cycle.
    rst_i[1] = 1'b0;
    push(1, 1, 3'd3, 4'd0, 32'd50, 32'd50);
    push(1, 2, 3'd3, 4'd0, 32'd50, 32'd3);
    tick(60);
    chk("t3_done", {31'd0, done_o[1]}, 32'd1);
    rst_i[1] = 1'b1;

    // Stall: progress change in RUN cycle 5, stall fires in RUN cycle 15.
    rst_i[2] = 1'b0;
    tick(5);
    prog_i[2][31:0] = 32'h3;
    push(2, 0, 3'd0, 4'd0, 32'h3, 32'd0);
    push(2, 1, 3'd4, 4'd0, 32'd15, 32'd15);
    push(2, 2, 3'd4, 4'd0, 32'd15, 32'd3);
    tick(20);
    chk("t4_done", {31'd0, done_o[2]}, 32'd1);

    // Pass-any mode; a fail during DRAIN is ignored, progress events continue.
    rst_i[2]  = 1'b1;
    prog_i[2] = 64'd0;
    tick(1);
    rst_i[2] = 1'b0;
    tick(3);
    pass_i[2][31:0] = 32'h1;
    push(2, 1, 3'd1, 4'd0, 32'h1, 32'd4);
    tick(2);
    fail_i[2][63:32] = 32'hBAD;
    tick(1);
    prog_i[2] = {32'h9, 32'h11};
    push(2, 0, 3'd0, 4'd0, 32'h11, 32'd0);
    push(2, 2, 3'd1, 4'd0, 32'h1, 32'd3);
    tick(6);
    chk("t6_verdict", {29'd0, verd_o[2]}, 32'd1);
    chk("t6_vval",    vval_o[2],          32'd1);

    tick(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
